// File: rtl/multi_button_debouncer_if.sv
// -----------------------------------------------------------------------------
// multi_button_debouncer_if
// Bundles the raw button pins and the conditioned per-channel outputs of the
// multi-button debouncer.
//   i_btn_in     : raw asynchronous button pins, one bit per channel
//   o_level      : debounced button state
//   o_press      : 1-cycle pulse on a debounced 0->1 transition
//   o_release    : 1-cycle pulse on a debounced 1->0 transition
//   o_long_press : 1-cycle pulse once per press after the hold time
//   o_repeat     : 1-cycle pulses at the repeat period after a long press
//   o_any_event  : registered OR of every pulse of every channel
// All outputs are single-cycle strobes with no valid/ready handshake: a
// consumer that is not looking in that cycle misses the event.
// modport slave  : the debouncer itself
// modport master : the pin driver / pulse consumer side
// -----------------------------------------------------------------------------
interface multi_button_debouncer_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] i_btn_in;
  logic [CHANNELS-1:0] o_level;
  logic [CHANNELS-1:0] o_press;
  logic [CHANNELS-1:0] o_release;
  logic [CHANNELS-1:0] o_long_press;
  logic [CHANNELS-1:0] o_repeat;
  logic                o_any_event;

  modport slave (
    input  i_btn_in,
    output o_level, o_press, o_release, o_long_press, o_repeat, o_any_event
  );

  modport master (
    output i_btn_in,
    input  o_level, o_press, o_release, o_long_press, o_repeat, o_any_event
  );
endinterface

// File: rtl/multi_button_debouncer.sv
// -----------------------------------------------------------------------------
// multi_button_debouncer
// N-channel push-button conditioner: synchroniser, counter debounce,
// press/release pulses, long-press pulse and optional auto-repeat per channel.
// Ports:
//   clock       : system clock
//   reset       : synchronous, active-high reset
//   bus         : multi_button_debouncer_if.slave (pins in, pulses out)
//   o_dbg_state : per-channel hold FSM state, 2 bits per channel
//                 (0 IDLE, 1 HELD, 2 REPEAT, 3 LATCHED), channel g at [2g+1:2g]
// -----------------------------------------------------------------------------
module multi_button_debouncer #(
  parameter int CHANNELS      = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic                      clock,
  input  logic                      reset,
  multi_button_debouncer_if.slave   bus,
  output logic [2*CHANNELS-1:0]     o_dbg_state
);

  localparam int DB_W     = $clog2(STABLE_CYCLES + 1);
  localparam int HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HC_W     = $clog2(HOLD_MAX + 1);

  // Counters compare against N-1 so that the action lands on the Nth cycle.
  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(STABLE_CYCLES - 1);
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
  localparam logic [HC_W-1:0] REP_LAST  = HC_W'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HELD    = 2'd1,
    ST_REPEAT  = 2'd2,
    ST_LATCHED = 2'd3
  } hold_state_t;

  logic [CHANNELS-1:0] w_level;
  logic [CHANNELS-1:0] w_press;
  logic [CHANNELS-1:0] w_release;
  logic [CHANNELS-1:0] w_long;
  logic [CHANNELS-1:0] w_repeat;
  logic                r_any_event;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] r_sync;
    logic [DB_W-1:0]        r_db_cnt;
    logic [HC_W-1:0]        r_hold_cnt;
    hold_state_t            r_state;
    logic                   r_level;
    logic                   r_press;
    logic                   r_release;
    logic                   r_long;
    logic                   r_repeat;
    logic                   w_s;
    logic                   w_settle;

    assign w_s      = r_sync[SYNC_STAGES-1];
    // Level flips on this edge: input has disagreed for STABLE_CYCLES cycles.
    assign w_settle = (w_s != r_level) && (r_db_cnt == DB_LAST);

    always_ff @(posedge clock) begin
      if (reset) begin
        r_sync     <= '0;
        r_db_cnt   <= '0;
        r_hold_cnt <= '0;
        r_state    <= ST_IDLE;
        r_level    <= 1'b0;
        r_press    <= 1'b0;
        r_release  <= 1'b0;
        r_long     <= 1'b0;
        r_repeat   <= 1'b0;
      end else begin
        r_sync    <= {r_sync[SYNC_STAGES-2:0], bus.i_btn_in[g]};
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_long    <= 1'b0;
        r_repeat  <= 1'b0;

        // Debounce: any agreeing cycle restarts the count.
        if (w_s == r_level) begin
          r_db_cnt <= '0;
        end else if (w_settle) begin
          r_level   <= w_s;
          r_db_cnt  <= '0;
          r_press   <= w_s;
          r_release <= ~w_s;
        end else begin
          r_db_cnt <= r_db_cnt + 1'b1;
        end

        // Hold FSM reacts to the level change on the same edge as the pulse,
        // so a release wins over a long-press/repeat falling in that cycle.
        if (w_settle && !w_s) begin
          r_state    <= ST_IDLE;
          r_hold_cnt <= '0;
        end else if (w_settle && w_s) begin
          r_state    <= ST_HELD;
          r_hold_cnt <= '0;
        end else begin
          case (r_state)
            ST_IDLE: r_hold_cnt <= '0;
            ST_HELD: begin
              if (r_hold_cnt == HOLD_LAST) begin
                r_long     <= 1'b1;
                r_hold_cnt <= '0;
                r_state    <= (REPEAT_CYCLES > 0) ? ST_REPEAT : ST_LATCHED;
              end else begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
              end
            end
            ST_REPEAT: begin
              if (r_hold_cnt == REP_LAST) begin
                r_repeat   <= 1'b1;
                r_hold_cnt <= '0;
              end else begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
              end
            end
            ST_LATCHED: r_hold_cnt <= '0;
            default: begin
              r_state    <= ST_IDLE;
              r_hold_cnt <= '0;
            end
          endcase
        end
      end
    end

    assign w_level[g]            = r_level;
    assign w_press[g]            = r_press;
    assign w_release[g]          = r_release;
    assign w_long[g]             = r_long;
    assign w_repeat[g]           = r_repeat;
    assign o_dbg_state[2*g +: 2] = r_state;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_any_event <= 1'b0;
    end else begin
      r_any_event <= |(w_press | w_release | w_long | w_repeat);
    end
  end

  assign bus.o_level      = w_level;
  assign bus.o_press      = w_press;
  assign bus.o_release    = w_release;
  assign bus.o_long_press = w_long;
  assign bus.o_repeat     = w_repeat;
  assign bus.o_any_event  = r_any_event;

endmodule

// File: tb/tb_multi_button_debouncer.sv
// -----------------------------------------------------------------------------
// tb_multi_button_debouncer
// Directed bench for multi_button_debouncer. DUT A: 4 channels with repeat,
// DUT B: 1 channel with repeat disabled. Inputs are driven #1 after a rising
// edge and outputs are sampled at that same point, so "after edge k" below
// means the registered values produced by rising edge k.
// -----------------------------------------------------------------------------
module tb_multi_button_debouncer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multi_button_debouncer_if #(.CHANNELS(4)) bus_a ();
  multi_button_debouncer_if #(.CHANNELS(1)) bus_b ();
  logic [7:0] dbg_a;
  logic [1:0] dbg_b;

  multi_button_debouncer #(
    .CHANNELS(4), .SYNC_STAGES(2), .STABLE_CYCLES(4),
    .HOLD_CYCLES(10), .REPEAT_CYCLES(3)
  ) dut_a (
    .clock(clk), .reset(rst), .bus(bus_a), .o_dbg_state(dbg_a)
  );

  multi_button_debouncer #(
    .CHANNELS(1), .SYNC_STAGES(2), .STABLE_CYCLES(4),
    .HOLD_CYCLES(10), .REPEAT_CYCLES(0)
  ) dut_b (
    .clock(clk), .reset(rst), .bus(bus_b), .o_dbg_state(dbg_b)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cnt_press   [4];
  int cnt_release [4];
  int cnt_level   [4];
  int cnt_long    [4];
  int cnt_rep     [4];
  int cnt_long_b, cnt_rep_b, cnt_rel_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    for (int c = 0; c < 4; c++) begin
      cnt_press[c] = 0; cnt_release[c] = 0; cnt_level[c] = 0;
      cnt_long[c]  = 0; cnt_rep[c]     = 0;
    end
    cnt_long_b = 0; cnt_rep_b = 0; cnt_rel_b = 0;
  endtask

  // One clock: wait for the rising edge, settle, then tally pulses.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++) begin
      if (bus_a.o_press[c])      cnt_press[c]++;
      if (bus_a.o_release[c])    cnt_release[c]++;
      if (bus_a.o_level[c])      cnt_level[c]++;
      if (bus_a.o_long_press[c]) cnt_long[c]++;
      if (bus_a.o_repeat[c])     cnt_rep[c]++;
    end
    if (bus_b.o_long_press[0]) cnt_long_b++;
    if (bus_b.o_repeat[0])     cnt_rep_b++;
    if (bus_b.o_release[0])    cnt_rel_b++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_level"},   32'(bus_a.o_level),      32'h0);
    check({tag, "_press"},   32'(bus_a.o_press),      32'h0);
    check({tag, "_release"}, 32'(bus_a.o_release),    32'h0);
    check({tag, "_long"},    32'(bus_a.o_long_press), 32'h0);
    check({tag, "_repeat"},  32'(bus_a.o_repeat),     32'h0);
    check({tag, "_any"},     32'(bus_a.o_any_event),  32'h0);
    check({tag, "_b_level"}, 32'(bus_b.o_level),      32'h0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic exp_long, exp_rep, exp_rel;
    bus_a.i_btn_in = 4'b0000;
    bus_b.i_btn_in = 1'b0;
    clear_counts();

    // Reset state, and the cycle after reset.
    rst = 1'b1;
    ticks(3);
    check_all_zero("rst_hold");
    rst = 1'b0;
    tick();
    check_all_zero("rst_after");

    // 1. Clean press on channel 0: sampled at edge 0, level/press after edge 5.
    bus_a.i_btn_in[0] = 1'b1;
    ticks(5);
    check("t1_level_e4", 32'(bus_a.o_level),   32'h0);
    check("t1_press_e4", 32'(bus_a.o_press),   32'h0);
    tick();
    check("t1_level_e5", 32'(bus_a.o_level),   32'h1);
    check("t1_press_e5", 32'(bus_a.o_press),   32'h1);
    check("t1_any_e5",   32'(bus_a.o_any_event), 32'h0);
    tick();
    check("t1_press_e6", 32'(bus_a.o_press),   32'h0);
    check("t1_any_e6",   32'(bus_a.o_any_event), 32'h1);
    tick();
    check("t1_any_e7",   32'(bus_a.o_any_event), 32'h0);
    // Release ch0 before its long-press: falling sampled at edge 8, release after edge 13.
    bus_a.i_btn_in[0] = 1'b0;
    ticks(5);
    check("t1_rel_e12",  32'(bus_a.o_release), 32'h0);
    tick();
    check("t1_rel_e13",  32'(bus_a.o_release), 32'h1);
    check("t1_lvl_e13",  32'(bus_a.o_level),   32'h0);
    ticks(3);

    // 2. Bounce on channel 1: 3 high / 1 low, five times; never 4 in a row.
    clear_counts();
    for (int r = 0; r < 5; r++) begin
      bus_a.i_btn_in[1] = 1'b1;
      ticks(3);
      bus_a.i_btn_in[1] = 1'b0;
      ticks(1);
    end
    ticks(10);
    check("t2_press_cnt",   32'(cnt_press[1]),   32'd0);
    check("t2_release_cnt", 32'(cnt_release[1]), 32'd0);
    check("t2_level_cnt",   32'(cnt_level[1]),   32'd0);

    // 3. Long press with repeat on channel 2. Press after edge P; long at P+10;
    //    repeats at P+13, P+16, ... Pin drops after P+31, sampled at P+32, so
    //    release lands at P+37, which would otherwise be a repeat slot.
    clear_counts();
    bus_a.i_btn_in[2] = 1'b1;
    ticks(6);
    check("t3_press", 32'(bus_a.o_press), 32'h4);
    for (int k = 1; k <= 40; k++) begin
      tick();
      exp_long = (k == 10);
      exp_rep  = (k >= 13) && (k < 37) && (((k - 10) % 3) == 0);
      exp_rel  = (k == 37);
      check($sformatf("t3_long_k%0d", k), 32'(bus_a.o_long_press[2]), 32'(exp_long));
      check($sformatf("t3_rep_k%0d", k),  32'(bus_a.o_repeat[2]),     32'(exp_rep));
      check($sformatf("t3_rel_k%0d", k),  32'(bus_a.o_release[2]),    32'(exp_rel));
      if (k == 31) bus_a.i_btn_in[2] = 1'b0;
    end
    check("t3_long_cnt", 32'(cnt_long[2]),    32'd1);
    check("t3_rep_cnt",  32'(cnt_rep[2]),     32'd8);
    check("t3_rel_cnt",  32'(cnt_release[2]), 32'd1);

    // 4. Repeat disabled (DUT B): hold 40 cycles, one long press, no repeats.
    clear_counts();
    bus_b.i_btn_in = 1'b1;
    ticks(6);
    check("t4_press", 32'(bus_b.o_press), 32'h1);
    ticks(40);
    check("t4_level_held", 32'(bus_b.o_level), 32'h1);
    bus_b.i_btn_in = 1'b0;
    ticks(8);
    check("t4_long_cnt", 32'(cnt_long_b), 32'd1);
    check("t4_rep_cnt",  32'(cnt_rep_b),  32'd0);
    check("t4_rel_cnt",  32'(cnt_rel_b),  32'd1);

    // 5. All four channels pressed together.
    bus_a.i_btn_in = 4'b1111;
    ticks(5);
    check("t5_press_e4", 32'(bus_a.o_press), 32'h0);
    tick();
    check("t5_press_e5", 32'(bus_a.o_press),     32'hF);
    check("t5_level_e5", 32'(bus_a.o_level),     32'hF);
    check("t5_any_e5",   32'(bus_a.o_any_event), 32'h0);
    tick();
    check("t5_press_e6", 32'(bus_a.o_press),     32'h0);
    check("t5_any_e6",   32'(bus_a.o_any_event), 32'h1);

    // 6. Reset at press+5 with pins held high; fresh press 5 cycles after
    //    reset deasserts, long press 10 cycles after that.
    ticks(3);
    rst = 1'b1;
    tick();
    check_all_zero("t6_rst");
    rst = 1'b0;
    tick();
    check_all_zero("t6_after");
    ticks(4);
    check("t6_press_r5", 32'(bus_a.o_press), 32'h0);
    tick();
    check("t6_press_r6", 32'(bus_a.o_press), 32'hF);
    check("t6_level_r6", 32'(bus_a.o_level), 32'hF);
    ticks(9);
    check("t6_long_p9",  32'(bus_a.o_long_press), 32'h0);
    tick();
    check("t6_long_p10", 32'(bus_a.o_long_press), 32'hF);
    tick();
    check("t6_long_p11", 32'(bus_a.o_long_press), 32'h0);
    check("t6_any_p11",  32'(bus_a.o_any_event),  32'h1);

    bus_a.i_btn_in = 4'b0000;
    ticks(10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
